// File: rtl/complete_encoder_pkg.sv
// Shared types and constants for the nibble prefix-code encoder.
// Code values are right-aligned in MAX_CODE_LEN bits and transmitted MSB first.
package complete_encoder_pkg;

  localparam int WORD_W       = 32;
  localparam int MAX_CODE_LEN = 6;
  localparam int ACC_W        = WORD_W + MAX_CODE_LEN;
  localparam int NIBBLES      = WORD_W / 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // sym0/1 are 2-bit, sym2/3 are 3-bit, sym4..15 are 11 followed by (sym-4)
  localparam logic [MAX_CODE_LEN-1:0] CODE_VAL [16] = '{
    6'b000000, 6'b000001, 6'b000100, 6'b000101,
    6'b110000, 6'b110001, 6'b110010, 6'b110011,
    6'b110100, 6'b110101, 6'b110110, 6'b110111,
    6'b111000, 6'b111001, 6'b111010, 6'b111011
  };

  localparam logic [2:0] CODE_LEN [16] = '{
    3'd2, 3'd2, 3'd3, 3'd3,
    3'd6, 3'd6, 3'd6, 3'd6,
    3'd6, 3'd6, 3'd6, 3'd6,
    3'd6, 3'd6, 3'd6, 3'd6
  };

endpackage

// File: rtl/complete_encoder_huffman.sv
// Combinational per-nibble code lookup: symbol in, right-aligned code and its length out.
module huffman_encode_3
  import complete_encoder_pkg::*;
(
  input  logic [3:0]              sym,
  output logic [MAX_CODE_LEN-1:0] code,
  output logic [2:0]              len
);

  assign code = CODE_VAL[sym];
  assign len  = CODE_LEN[sym];

endmodule

// File: rtl/complete_encoder.sv
// Packs prefix codes of each input nibble (MSB nibble first) into 32-bit output words;
// a flush request emits whatever partial word is pending.
module complete_encoder
  import complete_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] in,
  input  logic              flush,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [5:0]        out_nbits,
  output logic              out_valid
);

  localparam logic [6:0] ACC_W7   = 7'(ACC_W);
  localparam logic [6:0] WORD_W7  = 7'(WORD_W);
  localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

  state_t            state, state_d;
  logic [2:0]        idx, idx_d;
  logic [WORD_W-1:0] word, word_d;
  logic [ACC_W-1:0]  acc, acc_d;
  logic [5:0]        fill, fill_d;
  logic [WORD_W-1:0] out_data_d;
  logic [5:0]        out_nbits_d;
  logic              out_valid_d;

  logic [WORD_W-1:0]       word_sh;
  logic [3:0]              sym;
  logic [MAX_CODE_LEN-1:0] code;
  logic [2:0]              len;
  logic [6:0]              total;
  logic [6:0]              shamt;
  logic [ACC_W-1:0]        merged;

  assign word_sh = word << {idx, 2'b00};
  assign sym     = word_sh[WORD_W-1 -: 4];

  huffman_encode_3 u_lut (
    .sym  (sym),
    .code (code),
    .len  (len)
  );

  // Accumulator is left-aligned: the new code lands directly below the fill bits.
  assign total  = {1'b0, fill} + {4'b0000, len};
  assign shamt  = ACC_W7 - total;
  assign merged = acc | ({{(ACC_W-MAX_CODE_LEN){1'b0}}, code} << shamt);

  assign in_ready = (state == IDLE) && !flush;

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    word_d      = word;
    acc_d       = acc;
    fill_d      = fill;
    out_data_d  = out_data;
    out_nbits_d = out_nbits;
    out_valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          if (fill != 6'd0) state_d = FLUSH;
        end else if (load) begin
          word_d  = in;
          idx_d   = 3'd0;
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        idx_d = idx + 3'd1;
        if (total >= WORD_W7) begin
          out_data_d  = merged[ACC_W-1 -: WORD_W];
          out_nbits_d = 6'd32;
          out_valid_d = 1'b1;
          acc_d       = merged << WORD_W;
          fill_d      = 6'(total - WORD_W7);
        end else begin
          acc_d  = merged;
          fill_d = total[5:0];
        end
        if (idx == LAST_IDX) state_d = IDLE;
      end
      FLUSH: begin
        // Bits below fill are always zero, so the partial word is already padded.
        out_data_d  = acc[ACC_W-1 -: WORD_W];
        out_nbits_d = fill;
        out_valid_d = 1'b1;
        acc_d       = '0;
        fill_d      = 6'd0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      word      <= '0;
      acc       <= '0;
      fill      <= 6'd0;
      out_data  <= '0;
      out_nbits <= 6'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      word      <= word_d;
      acc       <= acc_d;
      fill      <= fill_d;
      out_data  <= out_data_d;
      out_nbits <= out_nbits_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_complete_encoder.sv
// Directed and randomized checks for complete_encoder, with a bit-level decoder as reference.
module tb_complete_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_w = 32'h0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [5:0]  out_nbits;
  logic        out_valid;

  always #5 clk = ~clk;

  complete_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .in        (in_w),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_nbits (out_nbits),
    .out_valid (out_valid)
  );

  int n_vec = 0;
  int n_err = 0;
  int b2b   = 0;
  logic        prev_v = 1'b0;
  logic [31:0] pd[$];
  logic [5:0]  pn[$];

  // Pulse recorder
  always @(negedge clk) begin
    if (out_valid) begin
      pd.push_back(out_data);
      pn.push_back(out_nbits);
      if (prev_v) b2b++;
    end
    prev_v = out_valid;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    load = 1'b1;
    in_w = w;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] w;
    bit          fl;
    int          np;
    logic [31:0] d0;
    logic [5:0]  n0;
    logic [31:0] d1;
    logic [5:0]  n1;
  } vec_t;

  vec_t tab[7];

  initial begin
    int base;
    int got;
    int pos;
    logic [31:0] w;
    logic [3:0]  exp_nib[$];
    logic [3:0]  dec[$];
    bit          bits[$];

    // Vectors chain: each row starts from the fill the previous row left behind.
    tab[0] = '{32'h00000000, 1'b1, 1, 32'h00000000, 6'd16, 32'h0, 6'd0};
    tab[1] = '{32'h11111111, 1'b1, 1, 32'h55550000, 6'd16, 32'h0, 6'd0};
    tab[2] = '{32'hFFFFFFFF, 1'b1, 2, 32'hEFBEFBEF, 6'd32, 32'hBEFB0000, 6'd16};
    tab[3] = '{32'h23232323, 1'b0, 0, 32'h0, 6'd0, 32'h0, 6'd0};
    tab[4] = '{32'h01234567, 1'b0, 1, 32'h96596519, 6'd32, 32'h0, 6'd0};
    tab[5] = '{32'h00000000, 1'b1, 2, 32'h70C72CC0, 6'd32, 32'h00000000, 6'd10};
    tab[6] = '{32'hCAFEBABE, 1'b1, 2, 32'hE36EFADF, 6'd32, 32'h6DFA0000, 6'd16};

    #1 rst = 1'b0;
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data",  64'(out_data),  64'd0);
    chk("reset_out_nbits", 64'(out_nbits), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      base = pd.size();
      load_word(tab[i].w);
      if (tab[i].fl) do_flush();
      got = pd.size() - base;
      chk($sformatf("v%0d_npulse", i), 64'(got), 64'(tab[i].np));
      if (tab[i].np >= 1 && got >= 1) begin
        chk($sformatf("v%0d_data0", i),  64'(pd[base]), 64'(tab[i].d0));
        chk($sformatf("v%0d_nbits0", i), 64'(pn[base]), 64'(tab[i].n0));
      end
      if (tab[i].np >= 2 && got >= 2) begin
        chk($sformatf("v%0d_data1", i),  64'(pd[base+1]), 64'(tab[i].d1));
        chk($sformatf("v%0d_nbits1", i), 64'(pn[base+1]), 64'(tab[i].n1));
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("hold_out_data",  64'(out_data),  64'h6DFA0000);
    chk("hold_out_nbits", 64'(out_nbits), 64'd16);
    chk("hold_out_valid", 64'(out_valid), 64'd0);

    // load/flush during ENCODE must be ignored
    base = pd.size();
    load = 1'b1; in_w = 32'h11111111;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    load = 1'b1; flush = 1'b1; in_w = 32'hFFFFFFFF;
    @(posedge clk); #1;
    load = 1'b0; flush = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    do_flush();
    chk("busy_npulse", 64'(pd.size() - base), 64'd1);
    if (pd.size() > base) begin
      chk("busy_data",  64'(pd[base]), 64'h55550000);
      chk("busy_nbits", 64'(pn[base]), 64'd16);
    end

    // load and flush together in IDLE with 16 bits pending: flush wins
    base = pd.size();
    load_word(32'h11111111);
    load = 1'b1; flush = 1'b1; in_w = 32'hFFFFFFFF;
    #1;
    chk("both_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    load = 1'b0; flush = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("both_npulse", 64'(pd.size() - base), 64'd1);
    if (pd.size() > base) begin
      chk("both_data",  64'(pd[base]), 64'h55550000);
      chk("both_nbits", 64'(pn[base]), 64'd16);
    end
    chk("both_not_accepted", 64'(in_ready), 64'd1);
    do_flush();
    chk("both_no_residue", 64'(pd.size() - base), 64'd1);

    // reset in the middle of a word
    load = 1'b1; in_w = 32'hFFFFFFFF;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data",  64'(out_data),  64'd0);
    chk("midrst_out_nbits", 64'(out_nbits), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    base = pd.size();
    do_flush();
    chk("midrst_flush_npulse", 64'(pd.size() - base), 64'd0);

    // random words with random flushes, decoded back from the output bitstream
    base = pd.size();
    for (int i = 0; i < 20; i++) begin
      w = $urandom;
      for (int k = 7; k >= 0; k--) exp_nib.push_back(w[4*k +: 4]);
      load_word(w);
      if ($urandom_range(0, 2) == 0) do_flush();
    end
    do_flush();
    for (int p = base; p < pd.size(); p++)
      for (int b = 0; b < int'(pn[p]); b++) bits.push_back(pd[p][31-b]);
    pos = 0;
    while (pos + 2 <= bits.size()) begin
      if (!bits[pos] && !bits[pos+1]) begin
        dec.push_back(4'd0); pos += 2;
      end else if (!bits[pos] && bits[pos+1]) begin
        dec.push_back(4'd1); pos += 2;
      end else if (!bits[pos+1]) begin
        if (pos + 3 > bits.size()) break;
        dec.push_back(bits[pos+2] ? 4'd3 : 4'd2); pos += 3;
      end else begin
        if (pos + 6 > bits.size()) break;
        dec.push_back(4'd4 + {bits[pos+2], bits[pos+3], bits[pos+4], bits[pos+5]});
        pos += 6;
      end
    end
    chk("rand_nsym", 64'(dec.size()), 64'(exp_nib.size()));
    chk("rand_leftover_bits", 64'(bits.size() - pos), 64'd0);
    for (int i = 0; i < exp_nib.size() && i < dec.size(); i++)
      chk($sformatf("rand_sym%0d", i), 64'(dec[i]), 64'(exp_nib[i]));

    chk("no_back_to_back_valid", 64'(b2b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
